nx_host_serdes: RTL

Byte-wide host link adapter sitting directly upstream of the Nexus top-level controller. It assembles host bytes into full `MESSAGE_WIDTH`-bit control messages for the controller's inbound stream. It also serialises the controller's `MESSAGE_WIDTH`-bit responses back into bytes for the host. A receive timeout discards partially received messages so that a stalled or glitched host cannot leave the link misaligned.

---
 rtl/nx_host_serdes_pkg.sv | 23 ++
 rtl/nx_serdes_tx.sv | 83 ++++++++
 rtl/nx_host_serdes.sv | 115 +++++++++++
 3 files changed

// File: rtl/nx_host_serdes_pkg.sv
// Shared Nexus host-link constants: message geometry, message/response word types, TX FSM states.
// Latency: n/a (types and constants only).
// Backpressure: n/a.
package nx_host_serdes_pkg;

   localparam int MESSAGE_WIDTH   = 32;
   localparam int HOST_BYTE_WIDTH = 8;
   localparam int BYTES           = MESSAGE_WIDTH / HOST_BYTE_WIDTH;

   typedef logic [MESSAGE_WIDTH-1:0] control_message_t;
   typedef logic [MESSAGE_WIDTH-1:0] control_response_t;

   typedef enum logic {
      IDLE = 1'b0,
      SEND = 1'b1
   } nx_serdes_state_t;

   // Most-significant host byte of a message word; bytes travel MSB first.
   function automatic logic [HOST_BYTE_WIDTH-1:0] msb_byte(input logic [MESSAGE_WIDTH-1:0] word);
      return word[MESSAGE_WIDTH-1 -: HOST_BYTE_WIDTH];
   endfunction

endpackage

// File: rtl/nx_serdes_tx.sv
// Serialises controller response words into host bytes, most-significant byte first.
// Latency: first byte valid the cycle after the response handshake; BYTES host handshakes per word.
// Backpressure: holds byte while i_host_tx_ready low; takes a new response in IDLE or on the last-byte handshake.
//
// Ports:
//   i_clk, i_rst                                          clock, synchronous active-high reset
//   i_ctrl_resp / i_ctrl_resp_valid / o_ctrl_resp_ready   response word from the controller
//   o_host_tx_data / o_host_tx_valid / i_host_tx_ready    byte stream to the host
module nx_serdes_tx
   import nx_host_serdes_pkg::*;
(
   input  logic                       i_clk,
   input  logic                       i_rst,
   input  control_response_t          i_ctrl_resp,
   input  logic                       i_ctrl_resp_valid,
   output logic                       o_ctrl_resp_ready,
   output logic [HOST_BYTE_WIDTH-1:0] o_host_tx_data,
   output logic                       o_host_tx_valid,
   input  logic                       i_host_tx_ready
);

   localparam int CW = (BYTES < 2) ? 1 : $clog2(BYTES);
   localparam logic [CW-1:0] TX_LAST = CW'(BYTES - 1);

   nx_serdes_state_t  state_q, state_d;
   control_response_t tx_shift_q, tx_shift_d;
   logic [CW-1:0]     tx_count_q, tx_count_d;
   logic              resp_rdy;

   always_ff @(posedge i_clk) begin
      if (i_rst) begin
         state_q    <= IDLE;
         tx_shift_q <= '0;
         tx_count_q <= '0;
      end else begin
         state_q    <= state_d;
         tx_shift_q <= tx_shift_d;
         tx_count_q <= tx_count_d;
      end
   end

   always_comb begin
      state_d    = state_q;
      tx_shift_d = tx_shift_q;
      tx_count_d = tx_count_q;
      resp_rdy   = 1'b0;
      case (state_q)
         IDLE: begin
            resp_rdy = 1'b1;
            if (i_ctrl_resp_valid) begin
               tx_shift_d = i_ctrl_resp;
               tx_count_d = '0;
               state_d    = SEND;
            end
         end
         SEND: begin
            if (i_host_tx_ready) begin
               // Shifting zeros in leaves the register clear once the word is out,
               // so the data output reads 0 whenever nothing is being sent.
               tx_shift_d = {tx_shift_q[MESSAGE_WIDTH-HOST_BYTE_WIDTH-1:0], {HOST_BYTE_WIDTH{1'b0}}};
               tx_count_d = tx_count_q + 1'b1;
               if (tx_count_q == TX_LAST) begin
                  // Last byte leaves this cycle: accept the next response now so
                  // back-to-back words stream with no idle cycle.
                  resp_rdy   = 1'b1;
                  tx_count_d = '0;
                  state_d    = IDLE;
                  if (i_ctrl_resp_valid) begin
                     tx_shift_d = i_ctrl_resp;
                     state_d    = SEND;
                  end
               end
            end
         end
         default: state_d = IDLE;
      endcase
   end

   assign o_ctrl_resp_ready = i_rst | resp_rdy;
   assign o_host_tx_valid   = (state_q == SEND);
   assign o_host_tx_data    = msb_byte(tx_shift_q);

endmodule

// File: rtl/nx_host_serdes.sv
// Byte-wide host link adapter: assembles host bytes into control messages and serialises responses to bytes.
// Latency: o_ctrl_valid the cycle after the final RX byte; first TX byte the cycle after the response handshake.
// Backpressure: RX stalls only when the final byte cannot enter a still-held message slot; TX follows i_host_tx_ready.
//
// Ports:
//   i_clk, i_rst                                          clock, synchronous active-high reset
//   i_host_rx_data / i_host_rx_valid / o_host_rx_ready    bytes from the host, MSB first
//   o_host_tx_data / o_host_tx_valid / i_host_tx_ready    bytes to the host, MSB first
//   o_ctrl_data / o_ctrl_valid / i_ctrl_ready             assembled message to the controller
//   i_ctrl_resp / i_ctrl_resp_valid / o_ctrl_resp_ready   response word from the controller
//   o_rx_timeout                                          one-cycle pulse when a partial message is dropped
module nx_host_serdes
   import nx_host_serdes_pkg::*;
#(
   parameter int unsigned RX_TIMEOUT = 1024
)(
   input  logic                       i_clk,
   input  logic                       i_rst,
   input  logic [HOST_BYTE_WIDTH-1:0] i_host_rx_data,
   input  logic                       i_host_rx_valid,
   output logic                       o_host_rx_ready,
   output logic [HOST_BYTE_WIDTH-1:0] o_host_tx_data,
   output logic                       o_host_tx_valid,
   input  logic                       i_host_tx_ready,
   output control_message_t           o_ctrl_data,
   output logic                       o_ctrl_valid,
   input  logic                       i_ctrl_ready,
   input  control_response_t          i_ctrl_resp,
   input  logic                       i_ctrl_resp_valid,
   output logic                       o_ctrl_resp_ready,
   output logic                       o_rx_timeout
);

   localparam int CW = (BYTES < 2) ? 1 : $clog2(BYTES);
   localparam int TW = (RX_TIMEOUT < 2) ? 1 : $clog2(RX_TIMEOUT);
   localparam bit TO_EN = (RX_TIMEOUT != 0);
   localparam logic [CW-1:0] RX_LAST = CW'(BYTES - 1);
   // The timer only has to count up to RX_TIMEOUT-1: the idle cycle that
   // would take it to RX_TIMEOUT is the one that discards the partial message.
   localparam logic [TW-1:0] TO_LAST = TW'((RX_TIMEOUT == 0) ? 0 : RX_TIMEOUT - 1);

   control_message_t rx_shift_q;
   logic [CW-1:0]    rx_count_q;
   logic [TW-1:0]    rx_timer_q;
   control_message_t ctrl_dat_q;
   logic             ctrl_vld_q;
   logic             rx_timeout_q;

   logic             rx_accept;
   logic             rx_last;
   logic             ctrl_pop;
   logic             rx_expire;
   control_message_t rx_shift_next;

   assign rx_last       = (rx_count_q == RX_LAST);
   assign ctrl_pop      = ctrl_vld_q & i_ctrl_ready;
   // Only the completing byte needs the holding slot; it may enter in the
   // same cycle the held message is popped.
   assign o_host_rx_ready = i_rst | ~(rx_last & ctrl_vld_q & ~i_ctrl_ready);
   assign rx_accept     = i_host_rx_valid & o_host_rx_ready;
   assign rx_shift_next = {rx_shift_q[MESSAGE_WIDTH-HOST_BYTE_WIDTH-1:0], i_host_rx_data};
   // An accepted byte wins over an expiring timer.
   assign rx_expire     = TO_EN & ~rx_accept & (rx_count_q != '0) & (rx_timer_q == TO_LAST);

   always_ff @(posedge i_clk) begin
      if (i_rst) begin
         rx_shift_q   <= '0;
         rx_count_q   <= '0;
         rx_timer_q   <= '0;
         ctrl_dat_q   <= '0;
         ctrl_vld_q   <= 1'b0;
         rx_timeout_q <= 1'b0;
      end else begin
         rx_timeout_q <= rx_expire;

         if (rx_accept) begin
            rx_shift_q <= rx_shift_next;
            rx_timer_q <= '0;
            rx_count_q <= rx_last ? '0 : rx_count_q + 1'b1;
         end else if (rx_count_q == '0) begin
            rx_timer_q <= '0;
         end else if (rx_expire) begin
            rx_shift_q <= '0;
            rx_count_q <= '0;
            rx_timer_q <= '0;
         end else if (TO_EN) begin
            rx_timer_q <= rx_timer_q + 1'b1;
         end

         if (rx_accept && rx_last) begin
            ctrl_dat_q <= rx_shift_next;
            ctrl_vld_q <= 1'b1;
         end else if (ctrl_pop) begin
            ctrl_dat_q <= '0;
            ctrl_vld_q <= 1'b0;
         end
      end
   end

   assign o_ctrl_data  = ctrl_dat_q;
   assign o_ctrl_valid = ctrl_vld_q;
   assign o_rx_timeout = rx_timeout_q;

   nx_serdes_tx u_tx (
      .i_clk             (i_clk),
      .i_rst             (i_rst),
      .i_ctrl_resp       (i_ctrl_resp),
      .i_ctrl_resp_valid (i_ctrl_resp_valid),
      .o_ctrl_resp_ready (o_ctrl_resp_ready),
      .o_host_tx_data    (o_host_tx_data),
      .o_host_tx_valid   (o_host_tx_valid),
      .i_host_tx_ready   (i_host_tx_ready)
   );

endmodule
